// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Holds default widths/counts and a constant-foldable clog2.
package regfile_pkg;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;
    localparam int NRD_D   = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// rf_scoreboard: one busy bit per register, set by mark, cleared by writes.
// Ports: clk, reset, mark_en/addr, clr0/clr1 en/addr, qa (NRD addrs) -> qbusy.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_D,
    parameter int NRD   = NRD_D,
    parameter int AW    = clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mark_en,
    input  logic [AW-1:0]     mark_addr,
    input  logic              clr0_en,
    input  logic [AW-1:0]     clr0_addr,
    input  logic              clr1_en,
    input  logic [AW-1:0]     clr1_addr,
    input  logic [NRD*AW-1:0] qa,
    output logic [NRD-1:0]    qbusy
);

    logic [NREGS-1:0] busy;

    function automatic logic clr_hit(input logic [AW-1:0] a);
        return (clr0_en && clr0_addr == a) ||
               (clr1_en && clr1_addr == a);
    endfunction

    // Entry 0 is never set; mark takes priority over a same-cycle clear
    // because the new producer is younger than the completing write.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (mark_en && mark_addr == AW'(r))
                    busy[r] <= 1'b1;
                else if (clr_hit(AW'(r)))
                    busy[r] <= 1'b0;
            end
        end
    end

    // A write completing this cycle makes the register readable now.
    always_comb begin
        qbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            qbusy[i] = (qa[i*AW +: AW] != '0) &&
                       busy[qa[i*AW +: AW]] &&
                       !clr_hit(qa[i*AW +: AW]);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-write, NRD-read register file with byte enables, bypass and scoreboard.
// Ports: clk, reset, ra/rd/rd_busy (reads), we/wa/wd/wbe x2, mark_en/addr.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_D,
    parameter  int NREGS = NREGS_D,
    parameter  int NRD   = NRD_D,
    localparam int AW    = clog2(NREGS),
    localparam int BW    = XLEN / 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic [BW-1:0]       wbe0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic [BW-1:0]       wbe1,
    input  logic                mark_en,
    input  logic [AW-1:0]       mark_addr
);

    // x0 is not stored; it is synthesised as zero on the read side.
    logic [XLEN-1:0] regs [1:NREGS-1];
    logic [XLEN-1:0] nxt  [1:NREGS-1];

    // Value register a will hold after this edge; port 1 wins per byte.
    function automatic logic [XLEN-1:0] merge(
        input logic [XLEN-1:0] cur,
        input logic [AW-1:0]   a
    );
        logic [XLEN-1:0] v;
        v = cur;
        for (int k = 0; k < BW; k++) begin
            if (we1 && wa1 == a && wbe1[k])
                v[k*8 +: 8] = wd1[k*8 +: 8];
            else if (we0 && wa0 == a && wbe0[k])
                v[k*8 +: 8] = wd0[k*8 +: 8];
        end
        return v;
    endfunction

    always_comb begin
        for (int r = 1; r < NREGS; r++)
            nxt[r] = merge(regs[r], AW'(r));
    end

    always_ff @(posedge clk) begin
        for (int r = 1; r < NREGS; r++) begin
            if (reset) regs[r] <= '0;
            else       regs[r] <= nxt[r];
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ra[i*AW +: AW] != '0)
                rd[i*XLEN +: XLEN] = merge(regs[ra[i*AW +: AW]],
                                           ra[i*AW +: AW]);
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .clr0_en   (we0 && (|wbe0)),
        .clr0_addr (wa0),
        .clr1_en   (we1 && (|wbe1)),
        .clr1_addr (wa1),
        .qa        (ra),
        .qbusy     (rd_busy)
    );

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits; multiple of 8.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, at least 2.
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1 to 4.
REQ-004 SHALL derive localparam AW = clog2(NREGS) and BW = XLEN/8.
REQ-005 SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port ra, input, NRD*AW bits: read addresses, port i at bits [i*AW +: AW].
REQ-008 SHALL have port rd, output, NRD*XLEN bits: read data, port i at bits [i*XLEN +: XLEN].
REQ-009 SHALL have port rd_busy, output, NRD bits: pending-write flag per read port.
REQ-010 SHALL have ports we0/we1, input, 1 bit each: write enables for write ports 0 and 1.
REQ-011 SHALL have ports wa0/wa1, input, AW bits each: write addresses.
REQ-012 SHALL have ports wd0/wd1, input, XLEN bits each: write data.
REQ-013 SHALL have ports wbe0/wbe1, input, BW bits each: byte enables, bit k covers byte k.
REQ-014 SHALL have ports mark_en (1 bit) and mark_addr (AW bits), inputs: scoreboard reservation of a destination register.

Function
REQ-015 Register 0 SHALL read as 0 at all times; writes and marks to address 0 SHALL be ignored.
REQ-016 A write SHALL update only the bytes whose wbe bit is 1, at the rising edge; other bytes hold.
REQ-017 When both write ports target the same nonzero address, byte lanes enabled on port 1 SHALL take wd1, and lanes enabled only on port 0 SHALL take wd0.
REQ-018 Reads SHALL be combinational, with same-cycle bypass: rd for a port SHALL equal the value the register will hold after the current edge's writes, merged per byte with REQ-017 priority.
REQ-019 The scoreboard SHALL hold one busy bit per register; mark_en sets busy[mark_addr] at the edge.
REQ-020 Any write with at least one wbe bit set SHALL clear busy[wa] at the edge; a write with wbe all zero SHALL change neither data nor busy.
REQ-021 A mark and a write to the same register in the same cycle SHALL leave busy = 1 (new producer wins).
REQ-022 rd_busy[i] SHALL be busy[ra_i] AND NOT (a clearing write to ra_i in this cycle); rd_busy SHALL be 0 for address 0.
REQ-023 Write-to-read latency SHALL be 0 cycles via bypass; mark-to-rd_busy latency SHALL be 1 cycle.

Reset
REQ-024 While reset is high at an edge, all registers SHALL become 0 and all busy bits 0; reset SHALL dominate writes and marks in that cycle.
REQ-025 In the cycle after reset, every rd SHALL be 0 and every rd_busy SHALL be 0, absent same-cycle writes.
REQ-026 Reset asserted mid-sequence SHALL discard all pending reservations; no partial state SHALL survive.

Structure
REQ-027 Package regfile_pkg SHALL hold the default XLEN, NREGS and NRD constants, plus the clog2 helper function.
REQ-028 The scoreboard SHALL be a sub-module rf_scoreboard, with inputs mark, two clear ports and NRD query ports.
REQ-029 Storage SHALL be a flip-flop array of NREGS-1 entries, with register 0 not stored.

Verification
REQ-030 Reset, then read all addresses: every rd = 0 and every rd_busy = 0.
REQ-031 Write x1 = 0xDEADBEEF with wbe = 4'b1111 while reading ra0 = 1 in the same cycle: rd0 = 0xDEADBEEF in that cycle and after.
REQ-032 Dual-port same-address write: we0 to x5 with 0x11111111 and wbe 4'b1111, plus we1 to x5 with 0x22222222 and wbe 4'b0011: x5 = 0x11112222.
REQ-033 Mark x7, then one cycle later: rd_busy = 1 for ra = 7. Then write x7 = 5: rd_busy = 0 in the write cycle, and rd = 5.
REQ-034 Same cycle, mark x9 and write x9 = 3: the next cycle reads x9 = 3 with rd_busy = 1.
REQ-035 Write x0 = 0xFFFFFFFF and mark x0, then assert reset with we1 active to x3: x0 reads 0 with rd_busy = 0, and x3 = 0 after reset.
